inst_cache_sa: RTL and testbench

//   N-way set-associative, read-only instruction cache between the fetch stage and the

---
 rtl/inst_cache_sa_if.sv | 30 +++
 rtl/inst_cache_sa.sv | 222 ++++++++++++++++++++++
 tb/tb_inst_cache_sa.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/inst_cache_sa_if.sv
// Fetch-side and memory-side signal bundle of the set-associative instruction cache.
// master: fetch stage plus instruction-memory port (drives requests and refill beats).
// slave : the cache (drives ready, fetched word, refill request and error flag).
interface inst_cache_sa_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 20
);
    logic                  valid;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  flush;
    logic                  ready;
    logic                  valid_out;
    logic [DATA_WIDTH-1:0] data;
    logic                  mem_valid_out;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_valid_in;
    logic                  mem_last;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  refill_err;

    modport master (
        output valid, addr, flush, mem_valid_in, mem_last, mem_data,
        input  ready, valid_out, data, mem_valid_out, mem_addr, refill_err
    );

    modport slave (
        input  valid, addr, flush, mem_valid_in, mem_last, mem_data,
        output ready, valid_out, data, mem_valid_out, mem_addr, refill_err
    );
endinterface

// File: rtl/inst_cache_sa.sv
// N-way set-associative read-only instruction cache with per-set round-robin
// replacement, early restart during refill and whole-cache flush.
// Ports:
//   clk, rst  clock (rising edge) and asynchronous active-high reset
//   bus       inst_cache_sa_if.slave: fetch request/response and burst refill port
//   hit_cnt, miss_cnt, flush_cnt  saturating statistics, only when
//             INST_CACHE_STATS_EN is defined
module inst_cache_sa #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 20,
    parameter int unsigned WAYS_WIDTH   = 1,
    parameter int unsigned INDEX_WIDTH  = 3,
    parameter int unsigned OFFSET_WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    inst_cache_sa_if.slave     bus
`ifdef INST_CACHE_STATS_EN
    ,
    output logic [31:0]        hit_cnt,
    output logic [31:0]        miss_cnt,
    output logic [15:0]        flush_cnt
`endif
);
    localparam int unsigned TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
    localparam int unsigned WAYS      = 1 << WAYS_WIDTH;
    localparam int unsigned SETS      = 1 << INDEX_WIDTH;
    localparam int unsigned WORDS     = 1 << OFFSET_WIDTH;
    localparam int unsigned WW        = (WAYS_WIDTH > 0) ? WAYS_WIDTH : 1;

    typedef enum logic [1:0] {S_READY, S_REFILL, S_FLUSH} state_t;

    state_t state_q, state_d;

    logic [TAG_WIDTH-1:0]  tag_mem  [WAYS][SETS];
    logic [DATA_WIDTH-1:0] data_mem [WAYS][SETS*WORDS];
    logic [WAYS-1:0]       line_valid [SETS];
    logic [WW-1:0]         rr [SETS];

    logic [TAG_WIDTH-1:0]    req_tag;
    logic [INDEX_WIDTH-1:0]  req_idx;
    logic [OFFSET_WIDTH-1:0] req_off;
    logic                    hit;
    logic [WW-1:0]           hit_way;
    logic [WW-1:0]           victim;
    logic                    accept;
    logic                    beat;

    logic [INDEX_WIDTH-1:0]  idx_q;
    logic [OFFSET_WIDTH-1:0] off_q;
    logic [WW-1:0]           victim_q;
    logic [OFFSET_WIDTH-1:0] beat_cnt;
    logic                    delivered;
    logic                    flush_pend;
    logic [INDEX_WIDTH-1:0]  fl_idx;

    assign req_tag = bus.addr[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign req_idx = bus.addr[OFFSET_WIDTH +: INDEX_WIDTH];
    assign req_off = bus.addr[OFFSET_WIDTH-1:0];
    assign accept  = bus.valid && bus.ready;
    assign beat    = (state_q == S_REFILL) && bus.mem_valid_in;

    // Tag compare and victim choice for the presented address.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        victim  = rr[req_idx];
        for (int w = 0; w < int'(WAYS); w++) begin
            if (line_valid[req_idx][w] && (tag_mem[w][req_idx] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
        end
        // Descending scan so the lowest-index invalid way wins.
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (!line_valid[req_idx][w]) begin
                victim = WW'(w);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_READY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_READY: begin
                if (bus.flush) begin
                    state_d = S_FLUSH;
                end else if (accept && !hit) begin
                    state_d = S_REFILL;
                end
            end
            S_REFILL: begin
                if (bus.mem_valid_in && bus.mem_last) begin
                    state_d = (flush_pend || bus.flush) ? S_FLUSH : S_READY;
                end
            end
            S_FLUSH: begin
                if (fl_idx == INDEX_WIDTH'(SETS - 1)) begin
                    state_d = S_READY;
                end
            end
            default: state_d = S_READY;
        endcase
    end

    // Combinational outputs.
    always_comb begin
        bus.ready = 1'b0;
        if ((state_q == S_READY) && !bus.flush && !flush_pend) begin
            bus.ready = 1'b1;
        end
    end

    // Control registers, valid bits and replacement pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.valid_out     <= 1'b0;
            bus.data          <= '0;
            bus.mem_valid_out <= 1'b0;
            bus.mem_addr      <= '0;
            bus.refill_err    <= 1'b0;
            idx_q             <= '0;
            off_q             <= '0;
            victim_q          <= '0;
            beat_cnt          <= '0;
            delivered         <= 1'b0;
            flush_pend        <= 1'b0;
            fl_idx            <= '0;
            for (int s = 0; s < int'(SETS); s++) begin
                line_valid[s] <= '0;
                rr[s]         <= '0;
            end
        end else begin
            bus.valid_out <= 1'b0;
            if (accept && hit) begin
                bus.valid_out <= 1'b1;
                bus.data      <= data_mem[hit_way][{req_idx, req_off}];
            end
            if (accept && !hit) begin
                idx_q                     <= req_idx;
                off_q                     <= req_off;
                victim_q                  <= victim;
                beat_cnt                  <= '0;
                delivered                 <= 1'b0;
                bus.mem_valid_out         <= 1'b1;
                bus.mem_addr              <= {req_tag, req_idx, {OFFSET_WIDTH{1'b0}}};
                // The victim stays invalid until a complete burst refills it.
                line_valid[req_idx][victim] <= 1'b0;
            end
            if (beat) begin
                bus.mem_valid_out <= 1'b0;
                beat_cnt          <= beat_cnt + OFFSET_WIDTH'(1);
                if ((beat_cnt == off_q) && !delivered) begin
                    bus.valid_out <= 1'b1;
                    bus.data      <= bus.mem_data;
                    delivered     <= 1'b1;
                end
                if (bus.mem_last) begin
                    if (beat_cnt == OFFSET_WIDTH'(WORDS - 1)) begin
                        line_valid[idx_q][victim_q] <= 1'b1;
                        rr[idx_q] <= (rr[idx_q] == WW'(WAYS - 1)) ? '0 : rr[idx_q] + WW'(1);
                    end else begin
                        bus.refill_err <= 1'b1;
                    end
                end
            end
            if ((state_q == S_REFILL) && bus.flush) begin
                flush_pend <= 1'b1;
            end
            if ((state_d == S_FLUSH) && (state_q != S_FLUSH)) begin
                flush_pend <= 1'b0;
                fl_idx     <= '0;
            end
            if (state_q == S_FLUSH) begin
                line_valid[fl_idx] <= '0;
                rr[fl_idx]         <= '0;
                fl_idx             <= fl_idx + INDEX_WIDTH'(1);
            end
        end
    end

    // Tag and data storage; contents are qualified by line_valid so no reset is needed.
    always_ff @(posedge clk) begin
        if (accept && !hit) begin
            tag_mem[victim][req_idx] <= req_tag;
        end
        if (beat) begin
            data_mem[victim_q][{idx_q, beat_cnt}] <= bus.mem_data;
        end
    end

`ifdef INST_CACHE_STATS_EN
    // Saturating event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt   <= '0;
            miss_cnt  <= '0;
            flush_cnt <= '0;
        end else begin
            if (accept && hit && (hit_cnt != '1)) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (accept && !hit && (miss_cnt != '1)) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
            if ((state_d == S_FLUSH) && (state_q != S_FLUSH) && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_inst_cache_sa.sv
// Self-checking bench for inst_cache_sa: table of directed fetches plus
// hand-written sequences for back-to-back hits, flush and reset corner cases.
module tb_inst_cache_sa;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 20;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    inst_cache_sa_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    inst_cache_sa #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .WAYS_WIDTH  (1),
        .INDEX_WIDTH (3),
        .OFFSET_WIDTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [AW-1:0] addr;
        int            last;
        logic          hit;
        logic [DW-1:0] data;
        logic [AW-1:0] maddr;
        logic          err;
    } vec_t;

    vec_t vecs [11];

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return 32'h0000_9FF0 + 32'(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // One fetch; serves a burst of last+1 beats on a miss, optionally pulsing flush on one beat.
    task automatic do_access(input logic [AW-1:0] a, input int last, input int fl_beat,
                             output logic hit, output logic [DW-1:0] d,
                             output logic [AW-1:0] maddr);
        logic [AW-1:0] base;
        int            deliveries;
        logic          responded;
        hit = 1'b0; d = '0; maddr = '0; deliveries = 0; responded = 1'b0;
        chk("ready_before_req", 32'(bus.ready), 32'd1);
        bus.valid = 1'b1;
        bus.addr  = a;
        @(posedge clk); #1;
        bus.valid = 1'b0;
        if (bus.valid_out) begin
            responded = 1'b1;
            hit       = 1'b1;
            d         = bus.data;
        end else if (bus.mem_valid_out) begin
            responded = 1'b1;
            maddr     = bus.mem_addr;
            base      = bus.mem_addr;
            for (int i = 0; i <= last; i++) begin
                bus.mem_valid_in = 1'b1;
                bus.mem_data     = mem_word(base + AW'(i));
                bus.mem_last     = (i == last);
                bus.flush        = (i == fl_beat);
                @(posedge clk); #1;
                bus.flush = 1'b0;
                if (i == 0) chk("mem_valid_drop", 32'(bus.mem_valid_out), 32'd0);
                if (bus.valid_out) begin
                    deliveries++;
                    d = bus.data;
                end
            end
            bus.mem_valid_in = 1'b0;
            bus.mem_last     = 1'b0;
            chk("early_restart_count", 32'(deliveries), 32'd1);
        end
        chk("req_response", 32'(responded), 32'd1);
    endtask

    task automatic apply_reset();
        bus.mem_valid_in = 1'b0;
        bus.mem_last     = 1'b0;
        bus.valid        = 1'b0;
        bus.flush        = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    logic          h;
    logic [DW-1:0] d;
    logic [AW-1:0] m;

    initial begin
        bus.valid = 1'b0; bus.addr = '0; bus.flush = 1'b0;
        bus.mem_valid_in = 1'b0; bus.mem_last = 1'b0; bus.mem_data = '0;

        vecs[0]  = '{20'h00013, 15, 1'b0, 32'hA003, 20'h00010, 1'b0};
        vecs[1]  = '{20'h0001F, 15, 1'b1, 32'hA00F, 20'h00000, 1'b0};
        vecs[2]  = '{20'h00022, 15, 1'b0, 32'hA012, 20'h00020, 1'b0};
        vecs[3]  = '{20'h000A5, 15, 1'b0, 32'hA095, 20'h000A0, 1'b0};
        vecs[4]  = '{20'h00127, 15, 1'b0, 32'hA117, 20'h00120, 1'b0};
        vecs[5]  = '{20'h000A0, 15, 1'b1, 32'hA090, 20'h00000, 1'b0};
        vecs[6]  = '{20'h00021, 15, 1'b0, 32'hA011, 20'h00020, 1'b0};
        vecs[7]  = '{20'h00128, 15, 1'b1, 32'hA118, 20'h00000, 1'b0};
        vecs[8]  = '{20'h00035,  9, 1'b0, 32'hA025, 20'h00030, 1'b1};
        vecs[9]  = '{20'h00031, 15, 1'b0, 32'hA021, 20'h00030, 1'b1};
        vecs[10] = '{20'h0003F, 15, 1'b1, 32'hA02F, 20'h00000, 1'b1};

        apply_reset();
        chk("rst_valid_out", 32'(bus.valid_out), 32'd0);
        chk("rst_data", bus.data, 32'd0);
        chk("rst_mem_valid_out", 32'(bus.mem_valid_out), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_refill_err", 32'(bus.refill_err), 32'd0);
        chk("rst_ready", 32'(bus.ready), 32'd1);

        // Cold miss, hits, round-robin eviction in set 2, short burst.
        for (int i = 0; i < 11; i++) begin
            do_access(vecs[i].addr, vecs[i].last, -1, h, d, m);
            chk($sformatf("v%0d_hit", i), 32'(h), 32'(vecs[i].hit));
            chk($sformatf("v%0d_data", i), d, vecs[i].data);
            if (!vecs[i].hit) chk($sformatf("v%0d_mem_addr", i), 32'(m), 32'(vecs[i].maddr));
            chk($sformatf("v%0d_refill_err", i), 32'(bus.refill_err), 32'(vecs[i].err));
        end

        // Back-to-back hits over the whole line at 0x10.
        for (int i = 0; i < 16; i++) begin
            bus.valid = 1'b1;
            bus.addr  = 20'h00010 + AW'(i);
            @(posedge clk); #1;
            chk("b2b_valid_out", 32'(bus.valid_out), 32'd1);
            chk("b2b_data", bus.data, mem_word(20'h00010 + AW'(i)));
            chk("b2b_no_mem_req", 32'(bus.mem_valid_out), 32'd0);
        end
        bus.valid = 1'b0;

        // Flush in READY beats a simultaneous request.
        bus.flush = 1'b1;
        bus.valid = 1'b1;
        bus.addr  = 20'h00010;
        #1;
        chk("flush_ready_low", 32'(bus.ready), 32'd0);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        bus.valid = 1'b0;
        chk("flush_req_not_hit", 32'(bus.valid_out), 32'd0);
        chk("flush_req_not_miss", 32'(bus.mem_valid_out), 32'd0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("flush_busy%0d", i), 32'(bus.ready), 32'd0);
            @(posedge clk); #1;
        end
        chk("flush_done_ready", 32'(bus.ready), 32'd1);
        do_access(20'h00013, 15, -1, h, d, m);
        chk("post_flush_miss", 32'(h), 32'd0);
        chk("post_flush_data", d, 32'hA003);

        // Flush during refill at beat 5: word delivered, then 8 flush cycles.
        do_access(20'h00045, 15, 5, h, d, m);
        chk("midflush_miss", 32'(h), 32'd0);
        chk("midflush_data", d, 32'hA035);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("midflush_busy%0d", i), 32'(bus.ready), 32'd0);
            @(posedge clk); #1;
        end
        chk("midflush_ready", 32'(bus.ready), 32'd1);
        do_access(20'h00045, 15, -1, h, d, m);
        chk("midflush_reread_miss", 32'(h), 32'd0);
        chk("midflush_reread_data", d, 32'hA035);

        // Reset while the refill request is pending drops it without a clock edge.
        bus.valid = 1'b1;
        bus.addr  = 20'h00200;
        @(posedge clk); #1;
        bus.valid = 1'b0;
        chk("pend_mem_valid_out", 32'(bus.mem_valid_out), 32'd1);
        chk("pend_mem_addr", 32'(bus.mem_addr), 32'h00200);
        rst = 1'b1;
        #1;
        chk("async_mem_valid_out", 32'(bus.mem_valid_out), 32'd0);
        chk("async_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("async_refill_err", 32'(bus.refill_err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset on beat 7 of a refill.
        bus.valid = 1'b1;
        bus.addr  = 20'h00013;
        @(posedge clk); #1;
        bus.valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.mem_valid_in = 1'b1;
            bus.mem_data     = mem_word(20'h00010 + AW'(i));
            @(posedge clk); #1;
        end
        bus.mem_data = mem_word(20'h00017);
        rst = 1'b1;
        #1;
        chk("beat7_rst_mem_valid_out", 32'(bus.mem_valid_out), 32'd0);
        chk("beat7_rst_valid_out", 32'(bus.valid_out), 32'd0);
        apply_reset();
        chk("beat7_rst_ready", 32'(bus.ready), 32'd1);
        do_access(20'h00045, 15, -1, h, d, m);
        chk("after_rst_miss_a", 32'(h), 32'd0);
        chk("after_rst_data_a", d, 32'hA035);
        do_access(20'h00013, 15, -1, h, d, m);
        chk("after_rst_miss_b", 32'(h), 32'd0);
        chk("after_rst_data_b", d, 32'hA003);
        do_access(20'h0001C, 15, -1, h, d, m);
        chk("after_rst_refilled_hit", 32'(h), 32'd1);
        chk("after_rst_refilled_data", d, 32'hA00C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety stop so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
